// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: slides a 10-bit window across two consecutive raw
// deserializer words until a run of DVI control tokens marks the symbol boundary.
module tmds_word_aligner #(
  parameter int TOKEN_RUN    = 8,
  parameter int DWELL        = 4096,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] raw_word,
  input  logic       resync,
  output logic [9:0] word_out,
  output logic       token_hit,
  output logic       aligned,
  output logic [3:0] offset
);

  localparam int RW = $clog2(TOKEN_RUN) + 1;
  localparam int DW = $clog2(DWELL) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [RW-1:0] RUN_LAST   = RW'(TOKEN_RUN - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_TIMEOUT - 1);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    prevWord_q, prevWord_d;
  logic [3:0]    offset_q, offset_d;
  logic [RW-1:0] runCnt_q, runCnt_d;
  logic [DW-1:0] dwellCnt_q, dwellCnt_d;
  logic [LW-1:0] sinceCnt_q, sinceCnt_d;
  logic [9:0]    wordOut_q, wordOut_d;
  logic          tokenHit_q, tokenHit_d;
  logic          aligned_q, aligned_d;

  logic [19:0]   concat;
  logic [9:0]    window;
  logic          isTok;
  logic [3:0]    nextOffset;

  // The previous word holds the earlier bits, so offset selects how far into
  // the 20-bit history the symbol boundary sits.
  always_comb begin
    concat     = {raw_word, prevWord_q};
    window     = 10'(concat >> offset_q);
    isTok      = (window == 10'h354) || (window == 10'h0AB) ||
                 (window == 10'h154) || (window == 10'h2AB);
    nextOffset = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    runCnt_d   = runCnt_q;
    dwellCnt_d = dwellCnt_q;
    sinceCnt_d = sinceCnt_q;
    prevWord_d = raw_word;
    wordOut_d  = window;
    tokenHit_d = isTok;

    if (resync) begin
      state_d    = SEARCH;
      offset_d   = nextOffset;
      runCnt_d   = '0;
      dwellCnt_d = '0;
      sinceCnt_d = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          // Lock beats a simultaneous dwell expiry so the offset that just
          // produced the token run is kept.
          if (isTok && (runCnt_q == RUN_LAST)) begin
            state_d    = LOCKED;
            runCnt_d   = '0;
            dwellCnt_d = '0;
            sinceCnt_d = '0;
          end else if (dwellCnt_q == DWELL_LAST) begin
            offset_d   = nextOffset;
            dwellCnt_d = '0;
            runCnt_d   = '0;
          end else begin
            runCnt_d   = isTok ? runCnt_q + RW'(1) : '0;
            dwellCnt_d = dwellCnt_q + DW'(1);
          end
        end
        LOCKED: begin
          if (isTok) begin
            sinceCnt_d = '0;
          end else if (sinceCnt_q == LOSS_LAST) begin
            state_d    = SEARCH;
            runCnt_d   = '0;
            dwellCnt_d = '0;
            sinceCnt_d = '0;
          end else begin
            sinceCnt_d = sinceCnt_q + LW'(1);
          end
        end
        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    aligned_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      prevWord_q <= '0;
      offset_q   <= '0;
      runCnt_q   <= '0;
      dwellCnt_q <= '0;
      sinceCnt_q <= '0;
      wordOut_q  <= '0;
      tokenHit_q <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prevWord_q <= prevWord_d;
      offset_q   <= offset_d;
      runCnt_q   <= runCnt_d;
      dwellCnt_q <= dwellCnt_d;
      sinceCnt_q <= sinceCnt_d;
      wordOut_q  <= wordOut_d;
      tokenHit_q <= tokenHit_d;
      aligned_q  <= aligned_d;
    end
  end

  assign word_out  = wordOut_q;
  assign token_hit = tokenHit_q;
  assign aligned   = aligned_q;
  assign offset    = offset_q;

endmodule

// File: doc/tmds_word_aligner.md
Name: tmds_word_aligner

Overview:
Receive-side counterpart of the HDMI TMDS serializer: one instance per TMDS channel, placed after the IO deserializer that delivers one unaligned 10-bit raw word per clk_pixel.
Finds the 10-bit symbol boundary by bit-slipping a 20-bit window until a run of DVI control tokens is seen during blanking.
Delivers aligned 10-bit symbols and a lock flag to the downstream TMDS decoder.

Parameters:
TOKEN_RUN, 8, consecutive control-token windows needed to declare lock (range 2..255)
DWELL, 4096, cycles spent at one slip offset before advancing (must exceed one video line; bench uses 16)
LOSS_TIMEOUT, 4096, consecutive token-free cycles while locked before lock is dropped (bench uses 16)

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
raw_word  in  10  unaligned deserialized bits; bit 0 = earliest received bit; new word every cycle
resync  in  1  single-cycle request: drop lock and advance offset
word_out  out  10  aligned TMDS symbol, bit 0 = first transmitted bit
token_hit  out  1  word_out is one of the four control tokens
aligned  out  1  lock state (1 = LOCKED)
offset  out  4  current slip offset, 0..9

Behaviour:
- Reset (async assert, sync use of deassert): prev word = 0, offset = 0, state = SEARCH, all counters = 0, word_out = 0, token_hit = 0, aligned = 0.
- Window: concat = {raw_word, prev} (20 bits, bit 0 earliest); window = concat[offset+9 : offset]. prev <= raw_word every edge.
- Control tokens (bit 9..0): 0x354, 0x0AB, 0x154, 0x2AB. is_tok = window matches any of them.
- Each edge: word_out <= window; token_hit <= is_tok. Latency for offset 0 is 2 edges from raw_word to word_out.
- State and counters update on the same edge, using is_tok of the window sampled at that edge. aligned is registered and equals (next state == LOCKED).
- SEARCH state:
  - run_cnt: incremented on is_tok, cleared on not is_tok.
  - dwell_cnt: incremented every cycle.
  - Lock: if is_tok and run_cnt == TOKEN_RUN-1, go to LOCKED and clear run_cnt, dwell_cnt and since_cnt.
  - Slip: otherwise, if dwell_cnt == DWELL-1, set offset <= (offset == 9) ? 0 : offset+1 and clear dwell_cnt and run_cnt.
  - If lock and dwell expiry fall on the same edge, lock wins and offset is unchanged.
- LOCKED state:
  - since_cnt: cleared on is_tok, incremented otherwise.
  - Loss: if not is_tok and since_cnt == LOSS_TIMEOUT-1, go to SEARCH with offset kept, all counters cleared and aligned = 0.
  - offset is never changed while LOCKED.
- resync = 1 in any state: go to SEARCH, advance offset with 9 -> 0 wrap, and clear all counters. It has priority over lock, loss and dwell events on the same edge.
- Counter widths are $clog2(param)+1. Counters never wrap; they are always cleared at their terminal value.
- Data-period characters (non-tokens) never affect offset while LOCKED.

Test Plan:
1. Continuous 0x354 from reset release at true alignment → aligned rises on the 9th edge (first window = prev = 0), offset = 0, word_out = 0x354, token_hit = 1.
2. Same token stream delayed by 3 bits, DWELL = 16 → offset steps 0→1→2→3 at edges 16/32/48 → aligned rises within TOKEN_RUN+1 edges after offset = 3; word_out = 0x354.
3. Locked, then 0x1F0 words only, LOSS_TIMEOUT = 16 → aligned falls exactly at the 16th non-token edge; offset is unchanged; SEARCH resumes at that offset.
4. At true alignment, 7×0x0AB, 1×0x1F0, 7×0x0AB repeating → aligned never rises; token_hit follows the pattern with 2-cycle latency.
5. Locked at offset 9, pulse resync → next edge aligned = 0 and offset = 0. Resync pulsed on the same edge as the 8th token → no lock.
6. Assert reset asynchronously mid-lock, between clock edges → aligned, token_hit, word_out and offset read 0 immediately. After release, test 1 repeats identically.
